// File: rtl/ir_pkg.sv
// ir_pkg: shared defaults and helpers for the instruction-register prefetch queue.
//   DATA_W_DEF / OPC_W_DEF / DEPTH_DEF : default instruction, opcode and queue sizes
//   NOP_OPC                            : opcode value the IR holds after reset
//   cnt_w(depth)                       : width needed to hold an occupancy of 0..depth
package ir_pkg;
    localparam int DATA_W_DEF = 8;
    localparam int OPC_W_DEF  = 4;
    localparam int DEPTH_DEF  = 4;

    localparam logic [OPC_W_DEF-1:0] NOP_OPC = '0;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction
endpackage

// File: rtl/ir_prefetch_queue_if.sv
// ir_prefetch_queue_if: fetch/control/status bundle between the controller side
// (master) and the prefetch queue + IR (slave).
//   Li, bus_in    : push an instruction word from the bus
//   advance       : move the queue head (or a bypassed bus word) into the IR
//   Ei            : enable the IR operand onto the tri-state bus
//   instruction   : IR opcode field
//   ir_valid      : IR holds a live instruction
//   full, empty, count, overflow : queue status
//   flush         : only present when IR_FLUSH_EN is defined; drops all prefetches
interface ir_prefetch_queue_if #(
    parameter int DATA_W = ir_pkg::DATA_W_DEF,
    parameter int OPC_W  = ir_pkg::OPC_W_DEF,
    parameter int DEPTH  = ir_pkg::DEPTH_DEF
);
    localparam int CNT_W = ir_pkg::cnt_w(DEPTH);

    logic              Li;
    logic [DATA_W-1:0] bus_in;
    logic              advance;
    logic              Ei;
`ifdef IR_FLUSH_EN
    logic              flush;
`endif
    logic [OPC_W-1:0]  instruction;
    logic              ir_valid;
    logic              full;
    logic              empty;
    logic [CNT_W-1:0]  count;
    logic              overflow;

    modport master (
`ifdef IR_FLUSH_EN
        output flush,
`endif
        output Li, bus_in, advance, Ei,
        input  instruction, ir_valid, full, empty, count, overflow
    );

    modport slave (
`ifdef IR_FLUSH_EN
        input  flush,
`endif
        input  Li, bus_in, advance, Ei,
        output instruction, ir_valid, full, empty, count, overflow
    );
endinterface

// File: rtl/ir_sync_fifo.sv
// ir_sync_fifo: DEPTH x DATA_W synchronous FIFO with show-ahead head output.
//   clk, clr : clock, synchronous active-high clear
//   push     : write wdata at the tail (caller guarantees room, or a same-cycle pop)
//   pop      : retire the head (caller guarantees non-empty)
//   flush    : drop all entries; wins over push/pop
//   rdata    : current head entry
//   count, full, empty : occupancy; full/empty decode the counter, not the pointers
module ir_sync_fifo
    import ir_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                      clk,
    input  logic                      clr,
    input  logic                      push,
    input  logic                      pop,
    input  logic                      flush,
    input  logic [DATA_W-1:0]         wdata,
    output logic [DATA_W-1:0]         rdata,
    output logic [cnt_w(DEPTH)-1:0]   count,
    output logic                      full,
    output logic                      empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wp;
    logic [AW-1:0]     rp;
    logic [CW-1:0]     cnt;

    // Pointers roll over naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (clr || flush) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (push) wp <= wp + AW'(1);
            if (pop)  rp <= rp + AW'(1);
            cnt <= cnt + CW'(push) - CW'(pop);
        end
    end

    // Storage needs no reset: nothing is read before it has been written.
    always_ff @(posedge clk) begin
        if (!clr && !flush && push) mem[wp] <= wdata;
    end

    assign rdata = mem[rp];
    assign count = cnt;
    assign full  = (cnt == CW'(DEPTH));
    assign empty = (cnt == '0);
endmodule

// File: rtl/ir_prefetch_queue.sv
// ir_prefetch_queue: instruction register fronted by a DEPTH-entry prefetch queue.
//   clk, clr : clock, synchronous active-high reset (priority over all else)
//   bus      : ir_prefetch_queue_if.slave (push/advance/Ei in, opcode + status out)
//   bus_out  : IR operand field when Ei=1, high-Z otherwise
// Optional macro IR_FLUSH_EN adds bus.flush, which empties the queue but keeps the IR.
module ir_prefetch_queue
    import ir_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int OPC_W  = OPC_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                    clk,
    input  logic                    clr,
    ir_prefetch_queue_if.slave      bus,
    output wire [DATA_W-OPC_W-1:0]  bus_out
);
    localparam int CW = cnt_w(DEPTH);
    localparam int OW = DATA_W - OPC_W;

    logic [DATA_W-1:0] ir;
    logic              ir_v;
    logic              ovf;
    logic [DATA_W-1:0] head;
    logic [CW-1:0]     fcount;
    logic              ffull;
    logic              fempty;
    logic              fl;
    logic              do_pop;
    logic              do_push;
    logic              bypass;
    logic              drop;

`ifdef IR_FLUSH_EN
    assign fl = bus.flush;
`else
    assign fl = 1'b0;
`endif

    // A pop in the same cycle frees the slot, so a full queue still accepts the push.
    always_comb begin
        do_pop  = 1'b0;
        bypass  = 1'b0;
        do_push = 1'b0;
        drop    = 1'b0;
        if (!fl) begin
            do_pop  = bus.advance && !fempty;
            bypass  = bus.advance && fempty && bus.Li;
            do_push = bus.Li && !bypass && (!ffull || do_pop);
            drop    = bus.Li && ffull && !do_pop;
        end
    end

    ir_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .clr   (clr),
        .push  (do_push),
        .pop   (do_pop),
        .flush (fl),
        .wdata (bus.bus_in),
        .rdata (head),
        .count (fcount),
        .full  (ffull),
        .empty (fempty)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            ir   <= {OPC_W'(NOP_OPC), OW'(0)};
            ir_v <= 1'b0;
            ovf  <= 1'b0;
        end else begin
            if (drop) ovf <= 1'b1;
            // Advance with nothing to load keeps the stale word but marks it dead.
            if (!fl && bus.advance) begin
                if (!fempty) begin
                    ir   <= head;
                    ir_v <= 1'b1;
                end else if (bus.Li) begin
                    ir   <= bus.bus_in;
                    ir_v <= 1'b1;
                end else begin
                    ir_v <= 1'b0;
                end
            end
        end
    end

    assign bus.instruction = ir[DATA_W-1 -: OPC_W];
    assign bus.ir_valid    = ir_v;
    assign bus.full        = ffull;
    assign bus.empty       = fempty;
    assign bus.count       = fcount;
    assign bus.overflow    = ovf;

    assign bus_out = bus.Ei ? ir[OW-1:0] : {OW{1'bz}};
endmodule

// File: tb/tb_ir_prefetch_queue.sv
// tb_ir_prefetch_queue: directed plus random stimulus against a queue-based
// reference model; expected post-edge state is queued by the driver and
// compared by an independent monitor.
module tb_ir_prefetch_queue;
    localparam int DW = 8;
    localparam int OW = 4;
    localparam int DEPTH = 4;

    typedef struct {
        logic        irv;
        logic [3:0]  opc;
        logic [3:0]  opr;
        logic        ei;
        int          cnt;
        logic        ovf;
    } exp_t;

    logic clk = 1'b0;
    logic clr = 1'b1;
    wire [DW-OW-1:0] bus_out;

    ir_prefetch_queue_if #(.DATA_W(DW), .OPC_W(OW), .DEPTH(DEPTH)) bif ();

    ir_prefetch_queue #(.DATA_W(DW), .OPC_W(OW), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .clr     (clr),
        .bus     (bif.slave),
        .bus_out (bus_out)
    );

    always #5 clk = ~clk;

    // reference model
    logic [7:0] mq[$];
    logic [7:0] m_ir;
    logic       m_irv;
    logic       m_ovf;
    exp_t       exp_q[$];

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input int act, input int expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    task automatic cyc(input bit c, input bit li, input logic [7:0] d,
                       input bit adv, input bit ei, input bit f);
        exp_t e;
        @(negedge clk);
        clr         = c;
        bif.Li      = li;
        bif.bus_in  = d;
        bif.advance = adv;
        bif.Ei      = ei;
`ifdef IR_FLUSH_EN
        bif.flush   = f;
`endif
        if (c) begin
            mq.delete();
            m_ir = 8'h00; m_irv = 1'b0; m_ovf = 1'b0;
        end else if (f) begin
            mq.delete();
        end else if (adv) begin
            if (mq.size() > 0) begin
                m_ir = mq.pop_front(); m_irv = 1'b1;
                if (li) mq.push_back(d);
            end else if (li) begin
                m_ir = d; m_irv = 1'b1;
            end else begin
                m_irv = 1'b0;
            end
        end else if (li) begin
            if (mq.size() < DEPTH) mq.push_back(d);
            else m_ovf = 1'b1;
        end
        e.irv = m_irv; e.opc = m_ir[7:4]; e.opr = m_ir[3:0];
        e.ei = ei; e.cnt = mq.size(); e.ovf = m_ovf;
        exp_q.push_back(e);
    endtask

    // monitor: every cycle the DUT presents its registered status
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("ir_valid", int'(bif.ir_valid), int'(e.irv));
                chk("instruction", int'(bif.instruction), int'(e.opc));
                chk("count", int'(bif.count), e.cnt);
                chk("full", int'(bif.full), int'(e.cnt == DEPTH));
                chk("empty", int'(bif.empty), int'(e.cnt == 0));
                chk("overflow", int'(bif.overflow), int'(e.ovf));
                if (e.ei) chk("bus_out", int'(bus_out), int'(e.opr));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit f;
        bif.Li = 1'b0; bif.bus_in = '0; bif.advance = 1'b0; bif.Ei = 1'b0;
`ifdef IR_FLUSH_EN
        bif.flush = 1'b0;
`endif
        // reset while a push is requested
        cyc(1, 1, 8'hA5, 0, 0, 0);
        cyc(0, 0, 8'h00, 0, 1, 0);
        // fill and overflow
        cyc(0, 1, 8'h11, 0, 0, 0);
        cyc(0, 1, 8'h22, 0, 0, 0);
        cyc(0, 1, 8'h33, 0, 0, 0);
        cyc(0, 1, 8'h44, 0, 0, 0);
        cyc(0, 1, 8'h55, 0, 0, 0);
        // drain in order, then advance on empty
        for (int i = 0; i < 5; i++) cyc(0, 0, 8'h00, 1, 1, 0);
        // bypass
        cyc(0, 1, 8'h9C, 1, 1, 0);
        // full push+pop
        cyc(0, 1, 8'hA1, 0, 0, 0);
        cyc(0, 1, 8'hA2, 0, 0, 0);
        cyc(0, 1, 8'hA3, 0, 0, 0);
        cyc(0, 1, 8'hA4, 0, 0, 0);
        cyc(0, 1, 8'h66, 1, 1, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 8'h00, 1, 1, 0);
`ifdef IR_FLUSH_EN
        cyc(1, 0, 8'h00, 0, 0, 0);
        cyc(0, 1, 8'h7E, 1, 1, 0);
        cyc(0, 1, 8'hB1, 0, 0, 0);
        cyc(0, 1, 8'hB2, 0, 0, 0);
        cyc(0, 1, 8'hB3, 0, 0, 0);
        cyc(0, 1, 8'hB4, 0, 1, 1);
        cyc(0, 1, 8'hB5, 0, 0, 0);
        cyc(0, 0, 8'h00, 1, 1, 1);
        cyc(0, 0, 8'h00, 1, 1, 0);
`endif
        // random traffic
        for (int i = 0; i < 800; i++) begin
            f = 1'b0;
`ifdef IR_FLUSH_EN
            f = ($urandom_range(15) == 0);
`endif
            cyc(($urandom_range(39) == 0), $urandom_range(1) == 1, 8'($urandom),
                $urandom_range(9) < 4, $urandom_range(1) == 1, f);
        end
        cyc(0, 0, 8'h00, 0, 0, 0);
        repeat (3) @(posedge clk);
        #3;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
